// File: rtl/l1_refill_arbiter.sv
// rtl/l1_refill_arbiter.sv - L1 I/D miss-refill arbiter, sequencer and LRU owner
//
// Arbitrates instruction- and data-side miss requests onto one memory read
// port, fetches the line, picks the victim way from the per-set LRU bit and
// writes the array. Also keeps the LRU bits current from lookup-hit reports.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imiss_req/addr/ack              instruction-side miss handshake
//   dmiss_req/addr/ack              data-side miss handshake
//   touch_valid/side/index/way      lookup-hit report for LRU update
//   mem_req/addr, mem_valid/rdata   shared line read port
//   fill_we/side/index/way/entry    array write, entry = {valid, tag, line}
//   busy                            refill in progress
//   err                             qualifies ack as failed refill
//
// Optional feature: define REFILL_TIMEOUT_EN to abandon a refill after
// REFILL_TIMEOUT cycles without mem_valid (acked with err=1, no fill).

module l1_refill_arbiter #(
  parameter int TAM_ADDR       = 16,
  parameter int TAG_W          = 3,
  parameter int INDEX_W        = 6,
  parameter int OFFSET_W       = 3,
  parameter int REFILL_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    imiss_req,
  input  logic [TAM_ADDR-1:0]     imiss_addr,
  output logic                    imiss_ack,
  input  logic                    dmiss_req,
  input  logic [TAM_ADDR-1:0]     dmiss_addr,
  output logic                    dmiss_ack,
  input  logic                    touch_valid,
  input  logic                    touch_side,
  input  logic [INDEX_W-1:0]      touch_index,
  input  logic                    touch_way,
  output logic                    mem_req,
  output logic [TAM_ADDR-1:0]     mem_addr,
  input  logic                    mem_valid,
  input  logic [63:0]             mem_rdata,
  output logic                    fill_we,
  output logic                    fill_side,
  output logic [INDEX_W-1:0]      fill_index,
  output logic                    fill_way,
  output logic [TAG_W+64:0]       fill_entry,
  output logic                    busy,
  output logic                    err
);

  localparam int NSETS = 1 << INDEX_W;

`ifdef REFILL_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_ERR} state_t;
  localparam int CNT_W = ($clog2(REFILL_TIMEOUT + 1) > 8) ? $clog2(REFILL_TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;
  logic [31:0] unused_timeout;
  assign unused_timeout = REFILL_TIMEOUT;
`endif

  state_t                     state_q, state_d;
  logic                       side_q, side_d;
  logic                       last_grant_q, last_grant_d;
  logic [TAM_ADDR-1:0]        addr_q, addr_d;
  logic [63:0]                line_q, line_d;
  // lru_q[side][set] holds the victim way for that set.
  logic [1:0][NSETS-1:0]      lru_q, lru_d;

  logic                       grant_side;
  logic [TAM_ADDR-1:0]        req_addr;
  logic [INDEX_W-1:0]         cur_index;
  logic [TAG_W-1:0]           cur_tag;
  logic                       victim_way;
  logic                       in_fill;
  logic                       in_err;
  logic                       unused_offset;

  // On a tie the side that did not win last time gets the port.
  assign grant_side = (imiss_req && dmiss_req) ? ~last_grant_q : dmiss_req;
  assign req_addr   = grant_side ? dmiss_addr : imiss_addr;
  assign unused_offset = ^{imiss_addr[OFFSET_W-1:0], dmiss_addr[OFFSET_W-1:0]};

  assign cur_index  = addr_q[OFFSET_W +: INDEX_W];
  assign cur_tag    = addr_q[OFFSET_W+INDEX_W +: TAG_W];
  assign victim_way = lru_q[side_q][cur_index];
  assign in_fill    = (state_q == S_FILL);

`ifdef REFILL_TIMEOUT_EN
  assign in_err = (state_q == S_ERR);
`else
  assign in_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    side_d       = side_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    line_d       = line_q;
    lru_d        = lru_q;
`ifdef REFILL_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    if (touch_valid) begin
      lru_d[touch_side][touch_index] = ~touch_way;
    end

    case (state_q)
      S_IDLE: begin
        if (imiss_req || dmiss_req) begin
          side_d       = grant_side;
          last_grant_d = grant_side;
          addr_d       = {req_addr[TAM_ADDR-1:OFFSET_W], {OFFSET_W{1'b0}}};
          state_d      = S_REQ;
`ifdef REFILL_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      S_REQ: begin
        if (mem_valid) begin
          line_d  = mem_rdata;
          state_d = S_FILL;
        end
`ifdef REFILL_TIMEOUT_EN
        else if (cnt_q == CNT_W'(REFILL_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_FILL: begin
        // Written after the touch update so a same-set fill takes priority.
        lru_d[side_q][cur_index] = ~victim_way;
        state_d = S_IDLE;
      end
`ifdef REFILL_TIMEOUT_EN
      S_ERR: begin
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      side_q       <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      line_q       <= '0;
      lru_q        <= '0;
`ifdef REFILL_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      side_q       <= side_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      lru_q        <= lru_d;
`ifdef REFILL_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Everything below decodes registered state only.
  assign mem_req    = (state_q == S_REQ);
  assign mem_addr   = addr_q;
  assign fill_we    = in_fill;
  assign fill_side  = in_fill & side_q;
  assign fill_index = in_fill ? cur_index : '0;
  assign fill_way   = in_fill & victim_way;
  assign fill_entry = in_fill ? {1'b1, cur_tag, line_q} : '0;
  assign imiss_ack  = (in_fill | in_err) & ~side_q;
  assign dmiss_ack  = (in_fill | in_err) & side_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = in_err;

endmodule

// File: tb/tb_l1_refill_arbiter.sv
// tb/tb_l1_refill_arbiter.sv - self-checking bench for l1_refill_arbiter

module tb_l1_refill_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imiss_req = 0, dmiss_req = 0;
  logic [15:0] imiss_addr = 0, dmiss_addr = 0;
  logic        imiss_ack, dmiss_ack;
  logic        touch_valid = 0, touch_side = 0, touch_way = 0;
  logic [5:0]  touch_index = 0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_valid = 0;
  logic [63:0] mem_rdata = 0;
  logic        fill_we, fill_side, fill_way, busy, err;
  logic [5:0]  fill_index;
  logic [67:0] fill_entry;

  l1_refill_arbiter #(.REFILL_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .imiss_req(imiss_req), .imiss_addr(imiss_addr), .imiss_ack(imiss_ack),
    .dmiss_req(dmiss_req), .dmiss_addr(dmiss_addr), .dmiss_ack(dmiss_ack),
    .touch_valid(touch_valid), .touch_side(touch_side),
    .touch_index(touch_index), .touch_way(touch_way),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_side(fill_side), .fill_index(fill_index),
    .fill_way(fill_way), .fill_entry(fill_entry), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: victim way per side/set and the last granted side.
  bit lru_m [2][64];
  bit last_grant_m;

  // Observations captured by the stimulus tasks.
  logic [15:0] o_mem_addr;
  logic        o_fill_we, o_fill_side, o_fill_way, o_iack, o_dack, o_err, o_timeout;
  logic [5:0]  o_fill_index;
  logic [67:0] o_fill_entry;
  int          o_lat;

  function automatic logic [5:0] idx_of(input logic [15:0] a);
    return 6'((a / 8) % 64);
  endfunction

  function automatic logic [2:0] tag_of(input logic [15:0] a);
    return 3'((a / 512) % 8);
  endfunction

  function automatic logic [15:0] line_of(input logic [15:0] a);
    return (a / 8) * 8;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; imiss_req = 0; dmiss_req = 0; mem_valid = 0; touch_valid = 0;
    @(negedge clk);
    rst = 0;
    foreach (lru_m[s, i]) lru_m[s][i] = 0;
    last_grant_m = 1;
  endtask

  task automatic raise(input bit side, input logic [15:0] a);
    if (side) begin dmiss_req = 1; dmiss_addr = a; end
    else begin imiss_req = 1; imiss_addr = a; end
  endtask

  task automatic drop(input bit side);
    if (side) dmiss_req = 0; else imiss_req = 0;
  endtask

  // Waits for mem_req, answers after 'delay' cycles, captures the fill cycle.
  task automatic serve(input logic [63:0] data, input int delay, input bit rnd_touch);
    bit ts, tw;
    int ti;
    o_timeout = 0; o_lat = 0; o_fill_we = 0; o_iack = 0; o_dack = 0; o_err = 0;
    o_fill_side = 0; o_fill_way = 0; o_fill_index = 0; o_fill_entry = '0; o_mem_addr = '0;
    while (1) begin
      @(negedge clk); o_lat++;
      if (mem_req) break;
      if (o_lat > 20) begin o_timeout = 1; return; end
    end
    o_mem_addr = mem_addr;
    for (int k = 0; k < delay; k++) begin
      if (rnd_touch && ($urandom % 2) == 1) begin
        ts = 1'($urandom % 2); ti = $urandom % 4; tw = 1'($urandom % 2);
        touch_valid = 1; touch_side = ts; touch_index = 6'(ti); touch_way = tw;
        lru_m[ts][ti] = !tw;
      end
      @(negedge clk); o_lat++;
      touch_valid = 0;
    end
    mem_valid = 1; mem_rdata = data;
    @(negedge clk); o_lat++;
    mem_valid = 0;
    o_fill_we = fill_we; o_fill_side = fill_side; o_fill_index = fill_index;
    o_fill_way = fill_way; o_fill_entry = fill_entry;
    o_iack = imiss_ack; o_dack = dmiss_ack; o_err = err;
  endtask

  task automatic refill(input bit side, input logic [15:0] a, input logic [63:0] data,
                        input int delay, input bit rnd_touch);
    raise(side, a);
    serve(data, delay, rnd_touch);
    drop(side);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({mem_req, fill_we, fill_side, fill_way, imiss_ack, dmiss_ack, busy, err} !== 8'h00) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 00000000",
        {mem_req, fill_we, fill_side, fill_way, imiss_ack, dmiss_ack, busy, err});
    end
    n_cmp++;
    if (mem_addr !== 16'h0 || fill_index !== 6'h0) begin
      n_bad++; $display("FAIL reset_addr: got %h/%h expected 0/0", mem_addr, fill_index);
    end
    n_cmp++;
    if (fill_entry !== 68'h0) begin
      n_bad++; $display("FAIL reset_entry: got %h expected 0", fill_entry);
    end
  endtask

  task automatic test_single_imiss();
    logic [63:0] d = 64'hDEADBEEF_01234567;
    logic [15:0] a = 16'h1238;
    do_reset();
    // Stray mem_valid while idle must be ignored.
    mem_valid = 1; mem_rdata = 64'h1;
    @(negedge clk); mem_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || fill_we !== 1'b0) begin
      n_bad++; $display("FAIL idle_mem_valid: got busy=%b fill_we=%b expected 0/0", busy, fill_we);
    end
    refill(0, a, d, 0, 0);
    n_cmp++;
    if (o_mem_addr !== 16'h1238) begin
      n_bad++; $display("FAIL single_mem_addr: got %h expected 1238", o_mem_addr);
    end
    n_cmp++;
    if ({o_fill_we, o_fill_side, o_fill_index, o_fill_way} !== {1'b1, 1'b0, 6'd7, 1'b0}) begin
      n_bad++; $display("FAIL single_fill: got we=%b side=%b idx=%0d way=%b expected 1/0/7/0",
        o_fill_we, o_fill_side, o_fill_index, o_fill_way);
    end
    n_cmp++;
    if (o_fill_entry !== {1'b1, tag_of(a), d}) begin
      n_bad++; $display("FAIL single_entry: got %h expected %h", o_fill_entry, {1'b1, tag_of(a), d});
    end
    n_cmp++;
    if ({o_iack, o_dack, o_err} !== 3'b100 || o_lat != 2) begin
      n_bad++; $display("FAIL single_ack: got iack=%b dack=%b err=%b lat=%0d expected 1/0/0/2",
        o_iack, o_dack, o_err, o_lat);
    end
    lru_m[0][7] = 1; last_grant_m = 0;
    refill(0, 16'h3238, 64'h55, 1, 0);
    n_cmp++;
    if (o_fill_way !== 1'b1) begin
      n_bad++; $display("FAIL single_lru_after: got way=%b expected 1", o_fill_way);
    end
    lru_m[0][7] = 0;
  endtask

  task automatic test_tie_order();
    logic [15:0] ia, da, a;
    bit first, s;
    bit exp_way;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      ia = 16'($urandom); da = 16'($urandom);
      imiss_addr = ia; dmiss_addr = da; imiss_req = 1; dmiss_req = 1;
      first = !last_grant_m;
      for (int k = 0; k < 2; k++) begin
        s = (k == 0) ? first : !first;
        a = s ? da : ia;
        exp_way = lru_m[s][idx_of(a)];
        serve(64'($urandom), 0, 0);
        n_cmp++;
        if ({o_iack, o_dack} !== {!s, s} || o_mem_addr !== line_of(a) || o_fill_way !== exp_way) begin
          n_bad++; $display("FAIL tie_order rep%0d grant%0d: got iack=%b dack=%b addr=%h way=%b expected side=%b addr=%h way=%b",
            rep, k, o_iack, o_dack, o_mem_addr, o_fill_way, s, line_of(a), exp_way);
        end
        lru_m[s][idx_of(a)] = !exp_way;
        last_grant_m = s;
        drop(s);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lru_dside();
    bit exp_ways [3] = '{0, 1, 1};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        touch_valid = 1; touch_side = 1; touch_index = 6'd5; touch_way = 0;
        @(negedge clk); touch_valid = 0;
      end
      refill(1, {4'($urandom), 3'($urandom), 6'd5, 3'($urandom)}, 64'($urandom), k, 0);
      n_cmp++;
      if (o_fill_way !== exp_ways[k] || o_fill_index !== 6'd5 || o_dack !== 1'b1) begin
        n_bad++; $display("FAIL lru_dside step%0d: got way=%b idx=%0d dack=%b expected %b/5/1",
          k, o_fill_way, o_fill_index, o_dack, exp_ways[k]);
      end
    end
    lru_m[1][5] = 0; last_grant_m = 1;
  endtask

  task automatic test_touch_fill_collision();
    int n;
    do_reset();
    raise(0, 16'h0018);
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    mem_valid = 1; mem_rdata = 64'hA5;
    @(negedge clk);
    mem_valid = 0;
    n_cmp++;
    if (fill_we !== 1'b1 || fill_way !== 1'b0 || fill_index !== 6'd3) begin
      n_bad++; $display("FAIL collide_fill: got we=%b way=%b idx=%0d expected 1/0/3", fill_we, fill_way, fill_index);
    end
    touch_valid = 1; touch_side = 0; touch_index = 6'd3; touch_way = 1;
    imiss_req = 0;
    @(negedge clk);
    touch_valid = 0;
    lru_m[0][3] = 1; last_grant_m = 0;
    refill(0, 16'h0418, 64'h5A, 0, 0);
    n_cmp++;
    if (o_fill_way !== 1'b1) begin
      n_bad++; $display("FAIL collide_lru: got way=%b expected 1", o_fill_way);
    end
    lru_m[0][3] = 0;
  endtask

  task automatic test_reset_mid_refill();
    int n;
    bit seen;
    do_reset();
    refill(1, 16'h0048, 64'h1, 0, 0);
    raise(1, 16'h0048);
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    rst = 1; dmiss_req = 0;
    @(negedge clk);
    rst = 0;
    n_cmp++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      n_bad++; $display("FAIL midrst_idle: got busy=%b mem_req=%b expected 0/0", busy, mem_req);
    end
    @(negedge clk);
    mem_valid = 1; mem_rdata = 64'hBAD;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_valid = 0;
      if (fill_we || imiss_ack || dmiss_ack || busy) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL midrst_quiet: got activity=%b expected 0", seen);
    end
    foreach (lru_m[s, i]) lru_m[s][i] = 0;
    last_grant_m = 1;
    refill(1, 16'h0448, 64'h2, 0, 0);
    n_cmp++;
    if (o_fill_way !== 1'b0 || o_fill_entry[63:0] !== 64'h2) begin
      n_bad++; $display("FAIL midrst_lru: got way=%b data=%h expected 0/2", o_fill_way, o_fill_entry[63:0]);
    end
    lru_m[1][9] = 1; last_grant_m = 1;
  endtask

  task automatic test_random();
    bit side, exp_way;
    logic [15:0] a;
    logic [63:0] d;
    int delay;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      side = 1'($urandom % 2);
      a = {4'($urandom), 3'($urandom), 6'($urandom % 4), 3'($urandom)};
      d = {$urandom, $urandom};
      delay = $urandom % 4;
      if ($urandom % 4 == 0) begin
        mem_valid = 1; @(negedge clk); mem_valid = 0;
      end
      refill(side, a, d, delay, 1);
      exp_way = lru_m[side][idx_of(a)];
      n_cmp++;
      if (o_timeout || o_mem_addr !== line_of(a) || o_fill_side !== side ||
          o_fill_index !== idx_of(a) || o_fill_way !== exp_way) begin
        n_bad++; $display("FAIL rand_fill it%0d: got to=%b addr=%h side=%b idx=%0d way=%b expected addr=%h side=%b idx=%0d way=%b",
          it, o_timeout, o_mem_addr, o_fill_side, o_fill_index, o_fill_way, line_of(a), side, idx_of(a), exp_way);
      end
      n_cmp++;
      if (o_fill_entry !== {1'b1, tag_of(a), d} || {o_iack, o_dack, o_err} !== {!side, side, 1'b0} ||
          o_lat != 2 + delay) begin
        n_bad++; $display("FAIL rand_ack it%0d: got entry=%h ack=%b%b err=%b lat=%0d expected entry=%h side=%b lat=%0d",
          it, o_fill_entry, o_iack, o_dack, o_err, o_lat, {1'b1, tag_of(a), d}, side, 2 + delay);
      end
      lru_m[side][idx_of(a)] = !exp_way;
      last_grant_m = side;
    end
  endtask

`ifdef REFILL_TIMEOUT_EN
  task automatic test_timeout();
    int req_cycles, n;
    bit any_fill;
    do_reset();
    raise(1, 16'h0010);
    req_cycles = 0; any_fill = 0; n = 0;
    while (n < 30) begin
      @(negedge clk); n++;
      if (mem_req) req_cycles++;
      if (fill_we) any_fill = 1;
      if (imiss_ack || dmiss_ack) break;
    end
    n_cmp++;
    if (dmiss_ack !== 1'b1 || err !== 1'b1 || req_cycles != 4 || any_fill) begin
      n_bad++; $display("FAIL timeout_err: got dack=%b err=%b req_cycles=%0d fill=%b expected 1/1/4/0",
        dmiss_ack, err, req_cycles, any_fill);
    end
    drop(1);
    @(negedge clk);
    last_grant_m = 1;
    refill(1, 16'h0210, 64'h77, 1, 0);
    n_cmp++;
    if (o_fill_we !== 1'b1 || o_dack !== 1'b1 || o_err !== 1'b0 || o_fill_way !== lru_m[1][2]) begin
      n_bad++; $display("FAIL timeout_next: got we=%b dack=%b err=%b way=%b expected 1/1/0/%b",
        o_fill_we, o_dack, o_err, o_fill_way, lru_m[1][2]);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_imiss();
    test_tie_order();
    test_lru_dside();
    test_touch_fill_collision();
    test_reset_mid_refill();
    test_random();
`ifdef REFILL_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
